// File: rtl/mem_bus_master.sv
// Initiator for the shared 16-bit data-memory bus: sequences 32-bit core loads/stores into halfword beats.
// Optional beat counters are enabled with `define MEM_BUS_PERF_EN.
module mem_bus_master #(
  parameter int ADDR_W = 20,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W:0]   req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] New_adr,
  inout  wire  [15:0]       MemData,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [31:0]       perf_rd_beats,
  output logic [31:0]       perf_wr_beats
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_TURN, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_err_q, resp_err_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;

  logic                lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic                we_q, we_d;
  logic                uns_q, uns_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                beat_q, beat_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [15:0]         lo_q, lo_d;
  logic [15:0]         wr_half_q, wr_half_d;

  logic                misaligned;
  logic                rd_done;
  logic [7:0]          rd_byte;
  logic [31:0]         load_result;

  assign misaligned = (req_size == 2'd3) ||
                      (req_size == 2'd2 && req_addr[1:0] != 2'b00) ||
                      (req_size == 2'd1 && req_addr[0]);
  assign rd_done    = (state_q == S_RD) && (lat_q == LAT_LAST);
  assign rd_byte    = lane_q ? MemData[15:8] : MemData[7:0];

  always_comb begin
    unique case (size_q)
      2'd2:    load_result = {MemData, lo_q};
      2'd1:    load_result = uns_q ? {16'h0000, MemData} : {{16{MemData[15]}}, MemData};
      default: load_result = uns_q ? {24'h000000, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
    endcase
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0;
    lane_d       = lane_q;
    size_d       = size_q;
    we_d         = we_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    beat_d       = beat_q;
    lat_d        = lat_q;
    lo_d         = lo_q;
    wr_half_d    = wr_half_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          lane_d  = req_addr[0];
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          beat_d  = 1'b0;
          lat_d   = '0;
          if (misaligned) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_we || req_size == 2'd0) begin
            // Loads and byte stores both start with a read beat.
            state_d = S_RD;
            adr_d   = req_addr[ADDR_W:1];
            rd_d    = 1'b1;
          end else begin
            state_d   = S_WR;
            adr_d     = req_addr[ADDR_W:1];
            wr_d      = 1'b1;
            wr_half_d = req_wdata[15:0];
          end
        end
      end
      S_RD: begin
        if (lat_q == LAT_LAST) begin
          lat_d = '0;
          if (size_q == 2'd2 && !beat_q) begin
            lo_d   = MemData;
            beat_d = 1'b1;
            adr_d  = adr_q + ADDR_W'(1);
            rd_d   = 1'b1;
          end else if (we_q) begin
            wr_half_d = lane_q ? {wdata_q[7:0], MemData[7:0]} : {MemData[15:8], wdata_q[7:0]};
            state_d   = S_TURN;
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_result;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
          rd_d  = 1'b1;
        end
      end
      S_TURN: begin
        state_d = S_WR;
        wr_d    = 1'b1;
      end
      S_WR: begin
        if (size_q == 2'd2 && !beat_q) begin
          beat_d    = 1'b1;
          adr_d     = adr_q + ADDR_W'(1);
          wr_half_d = wdata_q[31:16];
          wr_d      = 1'b1;
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      adr_q        <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // NOTE: datapath registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    lane_q    <= lane_d;
    size_q    <= size_d;
    we_q      <= we_d;
    uns_q     <= uns_d;
    wdata_q   <= wdata_d;
    beat_q    <= beat_d;
    lat_q     <= lat_d;
    lo_q      <= lo_d;
    wr_half_q <= wr_half_d;
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign New_adr    = adr_q;
  assign MemRead    = rd_q;
  assign MemWrite   = wr_q;
  assign MemData    = wr_q ? wr_half_q : 16'hzzzz;

`ifdef MEM_BUS_PERF_EN
  logic [31:0] perf_rd_q, perf_wr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_rd_q <= 32'h0;
      perf_wr_q <= 32'h0;
    end else begin
      if (rd_done) perf_rd_q <= perf_rd_q + 32'd1;
      if (wr_q)    perf_wr_q <= perf_wr_q + 32'd1;
    end
  end

  assign perf_rd_beats = perf_rd_q;
  assign perf_wr_beats = perf_wr_q;
`else
  assign perf_rd_beats = 32'h0;
  assign perf_wr_beats = 32'h0;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: one RD_LAT=1 instance with a 16-entry responder, one RD_LAT=3 instance for read timing.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [20:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, resp_valid, resp_err, MemWrite, MemRead;
  logic [31:0] resp_rdata, perf_rd_beats, perf_wr_beats;
  logic [19:0] New_adr;
  wire  [15:0] MemData;

  logic        req_valid3, req_ready3, resp_valid3, resp_err3, MemWrite3, MemRead3;
  logic [31:0] resp_rdata3, perf_rd3, perf_wr3;
  logic [19:0] New_adr3;
  wire  [15:0] MemData3;

  always #5 clk = ~clk;

  mem_bus_master #(.ADDR_W(20), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_err(resp_err), .resp_rdata(resp_rdata), .New_adr(New_adr),
    .MemData(MemData), .MemWrite(MemWrite), .MemRead(MemRead),
    .perf_rd_beats(perf_rd_beats), .perf_wr_beats(perf_wr_beats)
  );

  mem_bus_master #(.ADDR_W(20), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(1'b0), .req_size(2'd2), .req_unsigned(1'b0),
    .req_addr(21'h00010), .req_wdata(32'h0), .resp_valid(resp_valid3),
    .resp_err(resp_err3), .resp_rdata(resp_rdata3), .New_adr(New_adr3),
    .MemData(MemData3), .MemWrite(MemWrite3), .MemRead(MemRead3),
    .perf_rd_beats(perf_rd3), .perf_wr_beats(perf_wr3)
  );

  // Responders: 16 halfwords aliased on the low address bits.
  logic [15:0] mem  [16];
  logic [15:0] mem3 [16];
  always @(posedge clk) if (MemWrite) mem[New_adr[3:0]] <= MemData;
  assign MemData  = (MemRead && !MemWrite) ? mem[New_adr[3:0]] : 16'hzzzz;
  assign MemData3 = MemRead3 ? mem3[New_adr3[3:0]] : 16'hzzzz;

  // Per-cycle bus trace sampled on the falling edge.
  logic [1:0]  tr_q[$];
  logic [19:0] adr_log[$];
  logic [15:0] dat_log[$];
  int both_hi = 0, both3 = 0, rd3_cnt = 0;
  always @(negedge clk) begin
    tr_q.push_back({MemRead, MemWrite});
    adr_log.push_back(New_adr);
    dat_log.push_back(MemData);
    if (MemRead && MemWrite) both_hi++;
    if (MemRead3 && MemWrite3) both3++;
    if (MemRead3) rd3_cnt++;
  end

  int n_cmp = 0, n_mis = 0;
  int base, lat, rd3_base;
  logic err;
  logic [31:0] rd;
  logic seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [20:0] addr, input logic [31:0] wd);
    @(negedge clk);
    check("ready_before_req", req_ready, 1);
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    base = tr_q.size();
    lat = 0; err = 1'bx; rd = 32'hxxxxxxxx;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid) begin
        err = resp_err;
        rd  = resp_rdata;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0;
    req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 16; i++) mem3[i] = 16'h0000;
    mem3[8] = 16'h5678;
    mem3[9] = 16'h1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_new_adr", New_adr, 0);
    check("rst_memwrite", MemWrite, 0);
    check("rst_memread", MemRead, 0);
    reset = 1'b0;

    // Word store 0x12345678 at byte 0x10.
    do_req(1'b1, 2'd2, 1'b0, 21'h00010, 32'h12345678);
    check("sw_lat", lat, 3);
    check("sw_err", err, 0);
    check("sw_rdata", rd, 0);
    check("sw_tr0", tr_q[base], 2'b01);
    check("sw_tr1", tr_q[base+1], 2'b01);
    check("sw_tr2", tr_q[base+2], 2'b00);
    check("sw_adr0", adr_log[base], 20'h00008);
    check("sw_dat0", dat_log[base], 16'h5678);
    check("sw_adr1", adr_log[base+1], 20'h00009);
    check("sw_dat1", dat_log[base+1], 16'h1234);

    // Word load back, RD_LAT=1.
    do_req(1'b0, 2'd2, 1'b0, 21'h00010, 32'h0);
    check("lw_lat", lat, 3);
    check("lw_rdata", rd, 32'h12345678);
    check("lw_tr0", tr_q[base], 2'b10);
    check("lw_tr1", tr_q[base+1], 2'b10);
    check("lw_adr0", adr_log[base], 20'h00008);
    check("lw_adr1", adr_log[base+1], 20'h00009);

    // Word load, RD_LAT=3: six MemRead cycles then the response.
    @(negedge clk);
    check("lw3_ready", req_ready3, 1);
    req_valid3 = 1'b1;
    @(posedge clk);
    #1;
    req_valid3 = 1'b0;
    rd3_base = rd3_cnt;
    lat = 0; rd = 32'hxxxxxxxx; err = 1'bx;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (resp_valid3) begin
        rd  = resp_rdata3;
        err = resp_err3;
        break;
      end
    end
    check("lw3_lat", lat, 7);
    check("lw3_rdata", rd, 32'h12345678);
    check("lw3_err", err, 0);
    check("lw3_memread_cycles", rd3_cnt - rd3_base, 6);

    // Byte store 0xAB at 0x13: read 0x1234, turnaround, write 0xAB34.
    do_req(1'b1, 2'd0, 1'b0, 21'h00013, 32'h123456AB);
    check("sb_lat", lat, 4);
    check("sb_err", err, 0);
    check("sb_tr_read", tr_q[base], 2'b10);
    check("sb_tr_turn", tr_q[base+1], 2'b00);
    check("sb_tr_write", tr_q[base+2], 2'b01);
    check("sb_rd_adr", adr_log[base], 20'h00009);
    check("sb_wr_adr", adr_log[base+2], 20'h00009);
    check("sb_wr_dat", dat_log[base+2], 16'hAB34);

    // Byte and half loads with sign and zero extension.
    do_req(1'b0, 2'd0, 1'b0, 21'h00013, 32'h0);
    check("lb_lat", lat, 2);
    check("lb_signed", rd, 32'hFFFFFFAB);
    do_req(1'b0, 2'd0, 1'b1, 21'h00013, 32'h0);
    check("lbu", rd, 32'h000000AB);
    do_req(1'b0, 2'd0, 1'b0, 21'h00012, 32'h0);
    check("lb_low_lane", rd, 32'h00000034);
    do_req(1'b0, 2'd1, 1'b0, 21'h00012, 32'h0);
    check("lh_lat", lat, 2);
    check("lh_signed", rd, 32'hFFFFAB34);
    do_req(1'b0, 2'd1, 1'b1, 21'h00012, 32'h0);
    check("lhu", rd, 32'h0000AB34);

    // Illegal and misaligned requests.
    do_req(1'b0, 2'd2, 1'b0, 21'h00012, 32'h0);
    check("err_lw_lat", lat, 1);
    check("err_lw_err", err, 1);
    check("err_lw_rdata", rd, 0);
    check("err_lw_bus", tr_q[base], 2'b00);
    do_req(1'b0, 2'd3, 1'b0, 21'h00010, 32'h0);
    check("err_size3_lat", lat, 1);
    check("err_size3_err", err, 1);
    check("err_size3_bus", tr_q[base], 2'b00);
    do_req(1'b1, 2'd1, 1'b0, 21'h00011, 32'hFFFF);
    check("err_sh_odd_err", err, 1);
    check("err_sh_odd_bus", tr_q[base], 2'b00);

    // Top of the address space.
    do_req(1'b1, 2'd2, 1'b0, 21'h1FFFFC, 32'hCAFEBEEF);
    check("top_sw_lat", lat, 3);
    check("top_sw_adr0", adr_log[base], 20'hFFFFE);
    check("top_sw_dat0", dat_log[base], 16'hBEEF);
    check("top_sw_adr1", adr_log[base+1], 20'hFFFFF);
    check("top_sw_dat1", dat_log[base+1], 16'hCAFE);
    do_req(1'b0, 2'd2, 1'b0, 21'h1FFFFC, 32'h0);
    check("top_lw_rdata", rd, 32'hCAFEBEEF);
    do_req(1'b1, 2'd1, 1'b0, 21'h1FFFFE, 32'h00005A5A);
    check("top_sh_lat", lat, 2);
    check("top_sh_adr", adr_log[base], 20'hFFFFF);
    check("top_sh_dat", dat_log[base], 16'h5A5A);
    check("top_sh_tr", tr_q[base], 2'b01);
    do_req(1'b0, 2'd1, 1'b0, 21'h1FFFFE, 32'h0);
    check("top_lh_rdata", rd, 32'h00005A5A);
    do_req(1'b0, 2'd2, 1'b0, 21'h1FFFFE, 32'h0);
    check("top_lw_misaligned", err, 1);

    // Reset during beat 1 of a word store.
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 21'h00020; req_wdata = 32'hDDDDEEEE;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_beat0_wr", MemWrite, 1);
    check("rstmid_beat0_adr", New_adr, 20'h00010);
    @(negedge clk);
    check("rstmid_beat1_adr", New_adr, 20'h00011);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid_memwrite", MemWrite, 0);
    check("rstmid_memread", MemRead, 0);
    check("rstmid_resp_valid", resp_valid, 0);
    check("rstmid_ready", req_ready, 1);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || MemWrite || MemRead) seen = 1'b1;
    end
    check("rstmid_no_activity", seen, 0);

    // First request after the reset is served normally.
    do_req(1'b0, 2'd1, 1'b0, 21'h00010, 32'h0);
    check("post_rst_lat", lat, 2);
    check("post_rst_err", err, 0);
    check("post_rst_rdata", rd, 32'h00005678);

`ifdef MEM_BUS_PERF_EN
    check("perf_rd", perf_rd_beats, 1);
    check("perf_wr", perf_wr_beats, 0);
`else
    check("perf_rd_tied", perf_rd_beats, 0);
    check("perf_wr_tied", perf_wr_beats, 0);
`endif
    check("strobes_exclusive", both_hi, 0);
    check("strobes_exclusive3", both3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Initiator side of the shared data-memory bus: 20-bit halfword address, 16-bit bidirectional data, MemWrite/MemRead strobes.
- Accepts 32-bit load/store requests from the core through a valid/ready port and sequences them into 16-bit bus beats.
- Handles word splitting, byte read-modify-write, sign extension and bus turnaround.
- Sits between the core's LSU and dmem; dmem remains the responder.

Parameters:
- ADDR_W, 20, bus halfword-address width; the byte address is ADDR_W+1 bits.
- RD_LAT, 1, cycles MemRead is held per read beat; data is sampled at the edge ending the last cycle; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned  in  1  loads only: zero-extend instead of sign-extend.
- req_addr  in  ADDR_W+1  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualified by resp_valid; misaligned or illegal request.
- resp_rdata  out  32  load result; 0 for stores and errors.
- New_adr  out  ADDR_W  bus halfword address.
- MemData  inout  16  bus data; driven only while MemWrite=1, else high-Z.
- MemWrite  out  1  write strobe; responder writes at the rising edge.
- MemRead  out  1  read strobe; responder drives MemData combinationally.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, New_adr=0, MemWrite=0, MemRead=0, MemData=Z.
- Reset mid-operation: the in-flight request is dropped with no response; strobes are deasserted and the bus is released at that edge.
- Accept: handshake when req_valid && req_ready. req_ready=1 only in IDLE. All request fields are registered at acceptance.
- States: IDLE, RD, WR, TURN, RESP.
- Halfword index: idx = req_addr[ADDR_W:1].
- Alignment check at accept: word requires addr[1:0]=0; half requires addr[0]=0; size 3 is illegal. On failure go IDLE→RESP with no bus activity; resp_err=1.
- Word access: beat 0 at idx carries bits [15:0]; beat 1 at idx+1 carries bits [31:16] (little-endian). idx+1 wraps modulo 2^ADDR_W.
- Half access: one beat at idx.
- Byte load: one read beat at idx; select the high byte if addr[0]=1, else the low byte.
- Byte store: RMW. Read at idx, merge the byte into the lane selected by addr[0], then write at idx.
- Beat timing:
  - Read beat: MemRead=1 and New_adr valid for RD_LAT consecutive cycles; MemData captured at the final edge.
  - Write beat: MemWrite=1 for exactly 1 cycle with New_adr and MemData valid.
  - Consecutive beats of the same kind are back-to-back with no gap.
- Read→write transition (RMW only): exactly one TURN cycle with all strobes low and MemData=Z.
- MemRead and MemWrite are never high in the same cycle.
- Loads: 16/8-bit results are sign-extended unless req_unsigned=1.
- RESP: resp_valid=1 for one cycle, then IDLE. The next request may be accepted the cycle after RESP.
- Latency from accept edge to resp_valid (RD_LAT=1):
  - half load: 2 cycles
  - word load: 3 cycles
  - half store: 2 cycles
  - word store: 3 cycles
  - byte store: 4 cycles
  - error: 1 cycle
- Bus outputs are registered, so there are no combinational paths from req_* to bus pins.

Optional Feature:
- Macro: MEM_BUS_PERF_EN.
- Defined: adds outputs perf_rd_beats[31:0] and perf_wr_beats[31:0].
  - Each counts completed read/write beats and wraps at 2^32.
  - Both clear on reset.
- Undefined: the ports still exist, are tied to 0, and no counter flops are synthesised.

Test Plan:
- Word store 0x12345678 at byte 0x00010 → beats (adr 0x00008, 0x5678) then (0x00009, 0x1234); MemWrite high 2 cycles; resp_valid 3 cycles after accept, resp_err=0.
- Word load from 0x00010 after the above, RD_LAT=1 then RD_LAT=3 → resp_rdata=0x12345678; MemRead high 2 and 6 cycles respectively.
- Byte store 0xAB at 0x00013 → read idx 0x00009 (0x1234), one TURN cycle, write 0xAB34. Then signed byte load from 0x00013 → 0xFFFFFFAB; unsigned → 0x000000AB.
- Misaligned word load at 0x00012 and size=3 → resp_err=1 one cycle after accept; MemRead and MemWrite never asserted.
- Reset asserted during beat 1 of a word store → strobes low and MemData=Z after the reset edge; no resp_valid; req_ready=1; the next request is served normally.
- Wrap: word access at byte address 0x1FFFFC, ADDR_W=20 → beats at 0xFFFFE and 0xFFFFF. Half access at the top address 0x1FFFFE → beat at 0xFFFFF. A word at idx 0xFFFFF is misaligned and errors.
